// File: rtl/cmd_master.sv
// cmd_master: host-side initiator that turns single register read/write
// requests into protocol bytes for a UART and collects the one-byte read reply.
// Ports:
//   clk_i, rst_n_i            clock, async active-low reset
//   req_valid_i/req_ready_o   request handshake; req_wr_i, req_addr_i, req_wdata_i
//   rsp_valid_o               one-cycle completion pulse; rsp_rdata_o, rsp_err_o
//   tx_valid_o, tx_byte_o     byte launch to the UART transmitter; tx_busy_i
//   cts_i                     peer clear-to-send gate for each byte launch
//   rx_received_i, rx_byte_i  reply byte from the UART receiver; rx_error_i
module cmd_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       req_wr_i,
  input  logic [6:0] req_addr_i,
  input  logic [7:0] req_wdata_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic       rsp_err_o,
  output logic       tx_valid_o,
  output logic [7:0] tx_byte_o,
  input  logic       tx_busy_i,
  input  logic       cts_i,
  input  logic       rx_received_i,
  input  logic [7:0] rx_byte_i,
  input  logic       rx_error_i
);

  typedef enum logic [2:0] {
    IDLE,
    CMD_SEND,
    CMD_WAIT,
    DATA_SEND,
    DATA_WAIT,
    RSP_WAIT,
    DONE
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic             wr_q, wr_d;
  logic [6:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ready_q, ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rdata_q, rdata_d;
  logic             err_q, err_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_byte_q, tx_byte_d;

  always_comb begin
    state_d    = state_q;
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    seen_d     = seen_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    tx_valid_d = 1'b0;
    tx_byte_d  = tx_byte_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i && ready_q) begin
          wr_d    = req_wr_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          state_d = CMD_SEND;
        end
      end
      CMD_SEND: begin
        if (!tx_busy_i && cts_i) begin
          tx_valid_d = 1'b1;
          tx_byte_d  = {wr_q, addr_q};
          seen_d     = 1'b0;
          state_d    = CMD_WAIT;
        end
      end
      CMD_WAIT: begin
        // The UART raises busy a cycle after the launch pulse, so wait
        // for a busy period to be seen before treating busy=0 as done.
        if (tx_busy_i) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          if (wr_q) begin
            state_d = DATA_SEND;
          end else begin
            cnt_d   = '0;
            state_d = RSP_WAIT;
          end
        end
      end
      DATA_SEND: begin
        if (!tx_busy_i && cts_i) begin
          tx_valid_d = 1'b1;
          tx_byte_d  = wdata_q;
          seen_d     = 1'b0;
          state_d    = DATA_WAIT;
        end
      end
      DATA_WAIT: begin
        if (tx_busy_i) begin
          seen_d = 1'b1;
        end else if (seen_q) begin
          rdata_d = 8'h00;
          err_d   = 1'b0;
          state_d = DONE;
        end
      end
      RSP_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A received byte beats both a bare error strobe and the timeout.
        if (rx_received_i) begin
          rdata_d = rx_byte_i;
          err_d   = rx_error_i;
          state_d = DONE;
        end else if (rx_error_i || (cnt_q == CNT_LAST)) begin
          rdata_d = 8'h00;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d     = (state_d == IDLE);
    rsp_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      wr_q        <= 1'b0;
      addr_q      <= 7'h00;
      wdata_q     <= 8'h00;
      seen_q      <= 1'b0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 8'h00;
      err_q       <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_byte_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      seen_q      <= seen_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      tx_valid_q  <= tx_valid_d;
      tx_byte_q   <= tx_byte_d;
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;
  assign tx_valid_o  = tx_valid_q;
  assign tx_byte_o   = tx_byte_q;

endmodule

// File: tb/tb_cmd_master.sv
// tb_cmd_master: directed bench for cmd_master with a UART tx model
// (busy 10 cycles per byte) and a scripted reply source.
module tb_cmd_master;

  localparam int TO = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_wr = 1'b0;
  logic [6:0] req_addr = 7'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       tx_valid;
  logic [7:0] tx_byte;
  logic       tx_busy;
  logic       cts = 1'b1;
  logic       rx_received = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_error = 1'b0;

  always #5 clk = ~clk;

  cmd_master #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_wr_i(req_wr), .req_addr_i(req_addr),
    .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
    .rsp_err_o(rsp_err),
    .tx_valid_o(tx_valid), .tx_byte_o(tx_byte),
    .tx_busy_i(tx_busy), .cts_i(cts),
    .rx_received_i(rx_received), .rx_byte_i(rx_byte),
    .rx_error_i(rx_error)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // UART transmitter model: busy for 10 cycles after each launch.
  int         busy_cnt = 0;
  logic       txv_prev = 1'b0;
  int         consec = 0;
  logic [7:0] txq[$];
  always @(posedge clk) begin
    if (tx_valid) begin
      busy_cnt <= 10;
      txq.push_back(tx_byte);
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
    if (tx_valid && txv_prev) consec <= consec + 1;
    txv_prev <= tx_valid;
  end
  assign tx_busy = (busy_cnt != 0);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] qget(input int idx);
    if (idx < txq.size()) return txq[idx];
    return 8'h00;
  endfunction

  // kind: 0 no reply, 1 byte, 2 byte+error, 3 error strobe only
  typedef struct {
    string      name;
    logic       wr;
    logic [6:0] addr;
    logic [7:0] wd;
    int         kind;
    int         rdelay;
    logic [7:0] rbyte;
    int         ntx;
    logic [7:0] tx0;
    logic [7:0] tx1;
    logic [7:0] rd;
    logic       err;
    int         lat;
  } vec_t;

  typedef struct {
    int         ntx;
    logic [7:0] b0;
    logic [7:0] b1;
    logic       got;
    logic [7:0] rd;
    logic       er;
    int         lat;
    int         rdy_bad;
    logic       rdy_after;
  } res_t;

  task automatic run_req(input vec_t v, output res_t r);
    int n0;
    int tfall;
    int trsp;
    n0 = txq.size();
    tfall = 0;
    trsp = 0;
    r.got = 1'b0;
    r.rd = 8'h00;
    r.er = 1'b0;
    r.rdy_bad = 0;
    r.rdy_after = 1'b0;
    @(negedge clk);
    req_valid = 1'b1;
    req_wr = v.wr;
    req_addr = v.addr;
    req_wdata = v.wd;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wr = ~v.wr;
    req_addr = ~v.addr;
    req_wdata = ~v.wd;
    fork
      begin
        int k;
        k = 0;
        while (!tx_busy && k < 100) begin @(negedge clk); k++; end
        k = 0;
        while (tx_busy && k < 100) begin @(negedge clk); k++; end
        tfall = cyc;
        if (v.kind != 0) begin
          repeat (v.rdelay) @(negedge clk);
          rx_received = (v.kind == 1 || v.kind == 2);
          rx_error = (v.kind >= 2);
          rx_byte = v.rbyte;
          @(negedge clk);
          rx_received = 1'b0;
          rx_error = 1'b0;
          rx_byte = 8'h00;
        end
      end
      begin
        for (int i = 0; i < 400 && !r.got; i++) begin
          if (req_ready) r.rdy_bad++;
          if (rsp_valid) begin
            r.got = 1'b1;
            trsp = cyc;
            r.rd = rsp_rdata;
            r.er = rsp_err;
            @(negedge clk);
            r.rdy_after = req_ready;
          end else begin
            @(negedge clk);
          end
        end
      end
    join
    r.ntx = txq.size() - n0;
    r.b0 = qget(n0);
    r.b1 = qget(n0 + 1);
    r.lat = trsp - tfall;
  endtask

  vec_t vt[9];
  res_t r;
  int   n0;
  int   k;
  logic got;
  logic hold_bad;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{"wr12", 1'b1, 7'h12, 8'hA5, 0, 0, 8'h00,
              2, 8'h92, 8'hA5, 8'h00, 1'b0, -1};
    vt[1] = '{"rd05", 1'b0, 7'h05, 8'h00, 1, 50, 8'h3C,
              1, 8'h05, 8'h00, 8'h3C, 1'b0, 51};
    vt[2] = '{"rd_to", 1'b0, 7'h33, 8'h00, 0, 0, 8'h00,
              1, 8'h33, 8'h00, 8'h00, 1'b1, TO + 1};
    vt[3] = '{"wr7f", 1'b1, 7'h7F, 8'h00, 0, 0, 8'h00,
              2, 8'hFF, 8'h00, 8'h00, 1'b0, -1};
    vt[4] = '{"rd_byte_err", 1'b0, 7'h01, 8'h00, 2, 3, 8'h5A,
              1, 8'h01, 8'h00, 8'h5A, 1'b1, 4};
    vt[5] = '{"rd_err_only", 1'b0, 7'h40, 8'h00, 3, 5, 8'hEE,
              1, 8'h40, 8'h00, 8'h00, 1'b1, 6};
    vt[6] = '{"rd_same_to", 1'b0, 7'h22, 8'h00, 1, TO, 8'hC3,
              1, 8'h22, 8'h00, 8'hC3, 1'b0, TO + 1};
    vt[7] = '{"rd_late", 1'b0, 7'h22, 8'h00, 1, TO + 1, 8'h99,
              1, 8'h22, 8'h00, 8'h00, 1'b1, TO + 1};
    vt[8] = '{"rd00", 1'b0, 7'h00, 8'h00, 1, 1, 8'hFF,
              1, 8'h00, 8'h00, 8'hFF, 1'b0, 2};

    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_byte", tx_byte, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_req(vt[i], r);
      chk({vt[i].name, "_rsp"}, r.got, 1);
      chk({vt[i].name, "_ntx"}, r.ntx, vt[i].ntx);
      chk({vt[i].name, "_tx0"}, r.b0, vt[i].tx0);
      if (vt[i].ntx == 2) chk({vt[i].name, "_tx1"}, r.b1, vt[i].tx1);
      chk({vt[i].name, "_rdata"}, r.rd, vt[i].rd);
      chk({vt[i].name, "_err"}, r.er, vt[i].err);
      if (vt[i].lat >= 0) chk({vt[i].name, "_lat"}, r.lat, vt[i].lat);
      chk({vt[i].name, "_rdy_low"}, r.rdy_bad, 0);
      chk({vt[i].name, "_rdy_after"}, r.rdy_after, 1);
    end

    repeat (5) @(negedge clk);
    chk("hold_rdata", rsp_rdata, 8'hFF);
    chk("hold_err", rsp_err, 0);

    // cts gating of both bytes of a write
    cts = 1'b0;
    n0 = txq.size();
    @(negedge clk);
    req_valid = 1'b1;
    req_wr = 1'b1;
    req_addr = 7'h12;
    req_wdata = 8'h5C;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (40) @(negedge clk);
    chk("cts_hold_b0", txq.size() - n0, 0);
    cts = 1'b1;
    k = 0;
    while (!tx_busy && k < 50) begin @(negedge clk); k++; end
    chk("cts_b0_sent", txq.size() - n0, 1);
    cts = 1'b0;
    k = 0;
    while (tx_busy && k < 50) begin @(negedge clk); k++; end
    repeat (20) @(negedge clk);
    chk("cts_hold_b1", txq.size() - n0, 1);
    cts = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      if (rsp_valid) got = 1'b1;
      else @(negedge clk);
    end
    chk("cts_rsp", got, 1);
    chk("cts_err", rsp_err, 0);
    chk("cts_tx0", qget(n0), 8'h92);
    chk("cts_tx1", qget(n0 + 1), 8'h5C);

    // stray byte while idle is ignored
    repeat (2) @(negedge clk);
    rx_received = 1'b1;
    rx_byte = 8'h77;
    @(negedge clk);
    rx_received = 1'b0;
    rx_byte = 8'h00;
    hold_bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rsp_valid || rsp_rdata != 8'h00 || !req_ready) hold_bad = 1'b1;
      @(negedge clk);
    end
    chk("stray_ignored", hold_bad, 0);
    run_req('{"rd01", 1'b0, 7'h01, 8'h00, 1, 7, 8'h10,
              1, 8'h01, 8'h00, 8'h10, 1'b0, 8}, r);
    chk("stray_rd_rsp", r.got, 1);
    chk("stray_rd_tx0", r.b0, 8'h01);
    chk("stray_rd_rdata", r.rd, 8'h10);
    chk("stray_rd_err", r.er, 0);

    // async reset in the middle of RSP_WAIT
    @(negedge clk);
    req_valid = 1'b1;
    req_wr = 1'b0;
    req_addr = 7'h05;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    while (!tx_busy && k < 50) begin @(negedge clk); k++; end
    k = 0;
    while (tx_busy && k < 50) begin @(negedge clk); k++; end
    repeat (20) @(negedge clk);
    chk("pre_rst_tx_byte", tx_byte, 8'h05);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", req_ready, 1);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_rdata", rsp_rdata, 0);
    chk("arst_err", rsp_err, 0);
    chk("arst_tx_valid", tx_valid, 0);
    chk("arst_tx_byte", tx_byte, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_req('{"rd05b", 1'b0, 7'h05, 8'h00, 1, 10, 8'h3C,
              1, 8'h05, 8'h00, 8'h3C, 1'b0, 11}, r);
    chk("post_rst_rsp", r.got, 1);
    chk("post_rst_ntx", r.ntx, 1);
    chk("post_rst_rdata", r.rd, 8'h3C);
    chk("post_rst_err", r.er, 0);
    chk("post_rst_lat", r.lat, 11);

    chk("tx_valid_consecutive", consec, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
